// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage of a 5-stage MIPS-style pipeline.
//
// Decodes the fetched instruction and drives the register-file read addresses.
// Operands are forwarded from the EX/MEM and WB stages. A load-use hazard
// against the instruction held in ID/EX is detected, and the ID/EX pipeline
// register is updated each cycle.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   if_valid, if_instr, if_pc   instruction from fetch
//   flush                       kill the instruction entering ID/EX
//   reg_r_addr_1/2              register-file read addresses (rs, rt)
//   reg_r_data_1/2              register-file read data (combinational)
//   exm_w_en/dest/data          pending write in the EX/MEM stage
//   wb_w_en/dest/data           write in the WB stage
//   stall                       load-use hazard; fetch holds its outputs
//   id_*                        ID/EX pipeline register
// ---------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,

  output logic [4:0]  reg_r_addr_1,
  output logic [4:0]  reg_r_addr_2,
  input  logic [31:0] reg_r_data_1,
  input  logic [31:0] reg_r_data_2,

  input  logic        exm_w_en,
  input  logic [4:0]  exm_w_dest,
  input  logic [31:0] exm_w_data,
  input  logic        wb_w_en,
  input  logic [4:0]  wb_w_dest,
  input  logic [31:0] wb_w_data,

  output logic        stall,

  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_op_a,
  output logic [31:0] id_op_b,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic        id_w_en,
  output logic        id_is_load,
  output logic        id_is_store,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic [5:0] funct;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign funct  = if_instr[5:0];

  // Read addresses depend only on the instruction bits, not on valid or reset.
  assign reg_r_addr_1 = rs;
  assign reg_r_addr_2 = rt;

  // Operand select: the younger EX/MEM result wins over WB, which wins over
  // the register file. Register 0 is hard-wired to zero whatever is pending.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic        e_en,
    input logic [4:0]  e_dest,
    input logic [31:0] e_data,
    input logic        w_en,
    input logic [4:0]  w_dest,
    input logic [31:0] w_data
  );
    if (addr == 5'd0)                   return 32'd0;
    else if (e_en && (e_dest == addr))  return e_data;
    else if (w_en && (w_dest == addr))  return w_data;
    else                                return rf_data;
  endfunction

  logic [31:0] op_a, op_b, imm;

  assign op_a = fwd_sel(rs, reg_r_data_1, exm_w_en, exm_w_dest, exm_w_data,
                        wb_w_en, wb_w_dest, wb_w_data);
  assign op_b = fwd_sel(rt, reg_r_data_2, exm_w_en, exm_w_dest, exm_w_data,
                        wb_w_en, wb_w_dest, wb_w_data);
  assign imm  = {{16{if_instr[15]}}, if_instr[15:0]};

  // Control decode
  logic [4:0] dec_dest;
  logic       dec_w_en_raw;
  logic       dec_w_en;
  logic       dec_is_load;
  logic       dec_is_store;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    dec_dest     = 5'd0;
    dec_w_en_raw = 1'b0;
    dec_is_load  = 1'b0;
    dec_is_store = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_dest     = rd;
        dec_w_en_raw = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec_dest     = rt;
        dec_w_en_raw = 1'b1;
      end
      OP_LW: begin
        dec_dest     = rt;
        dec_w_en_raw = 1'b1;
        dec_is_load  = 1'b1;
      end
      OP_SW: begin
        dec_is_store = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes to register 0 are architecturally discarded, so they never forward.
  assign dec_w_en = dec_w_en_raw && (dec_dest != 5'd0);

  // Load-use: the load in ID/EX has no data until MEM, so the consumer waits
  // one cycle and then picks the value up through EX/MEM forwarding. rt is
  // compared for every opcode, which is conservative for I-type consumers.
  assign stall = if_valid && id_valid && id_is_load && (id_dest != 5'd0) &&
                 ((id_dest == rs) || (id_dest == rt));

  // ID/EX register. Priority: rst > flush > stall > normal load.
  // On flush or stall only the control bits are cleared; the datapath fields
  // are don't-care while id_valid is low, so they are simply held.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    if (rst) begin
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_op_a     <= 32'd0;
      id_op_b     <= 32'd0;
      id_imm      <= 32'd0;
      id_dest     <= 5'd0;
      id_w_en     <= 1'b0;
      id_is_load  <= 1'b0;
      id_is_store <= 1'b0;
      id_opcode   <= 6'd0;
      id_funct    <= 6'd0;
    end else if (flush || stall) begin
      id_valid    <= 1'b0;
      id_w_en     <= 1'b0;
      id_is_load  <= 1'b0;
      id_is_store <= 1'b0;
    end else begin
      id_valid    <= if_valid;
      id_pc       <= if_pc;
      id_op_a     <= op_a;
      id_op_b     <= op_b;
      id_imm      <= imm;
      id_dest     <= dec_dest;
      id_w_en     <= if_valid && dec_w_en;
      id_is_load  <= if_valid && dec_is_load;
      id_is_store <= if_valid && dec_is_store;
      id_opcode   <= opcode;
      id_funct    <= funct;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed self-checking bench for id_stage.
// Inputs change 1 time unit after each rising edge. Registered outputs are
// sampled at that same point. Combinational outputs are sampled 1 unit after
// the inputs change.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [4:0]  reg_r_addr_1, reg_r_addr_2;
  logic [31:0] reg_r_data_1, reg_r_data_2;
  logic        exm_w_en;
  logic [4:0]  exm_w_dest;
  logic [31:0] exm_w_data;
  logic        wb_w_en;
  logic [4:0]  wb_w_dest;
  logic [31:0] wb_w_data;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc, id_op_a, id_op_b, id_imm;
  logic [4:0]  id_dest;
  logic        id_w_en, id_is_load, id_is_store;
  logic [5:0]  id_opcode, id_funct;

  int n_vec = 0;
  int n_err = 0;

  // Register-file model: contents are set directly by the stimulus.
  logic [31:0] rf [32];
  assign reg_r_data_1 = (reg_r_addr_1 == 5'd0) ? 32'd0 : rf[reg_r_addr_1];
  assign reg_r_data_2 = (reg_r_addr_2 == 5'd0) ? 32'd0 : rf[reg_r_addr_2];

  always #5 clk = ~clk;

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush        (flush),
    .reg_r_addr_1 (reg_r_addr_1),
    .reg_r_addr_2 (reg_r_addr_2),
    .reg_r_data_1 (reg_r_data_1),
    .reg_r_data_2 (reg_r_data_2),
    .exm_w_en     (exm_w_en),
    .exm_w_dest   (exm_w_dest),
    .exm_w_data   (exm_w_data),
    .wb_w_en      (wb_w_en),
    .wb_w_dest    (wb_w_dest),
    .wb_w_data    (wb_w_data),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_op_a      (id_op_a),
    .id_op_b      (id_op_b),
    .id_imm       (id_imm),
    .id_dest      (id_dest),
    .id_w_en      (id_w_en),
    .id_is_load   (id_is_load),
    .id_is_store  (id_is_store),
    .id_opcode    (id_opcode),
    .id_funct     (id_funct)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h0000_0010;
    rf[2] = 32'h0000_0020;
    rf[3] = 32'h0000_0033;
    rf[4] = 32'h0000_0044;
    rf[5] = 32'h0000_0001;
    rf[8] = 32'h0000_0088;

    rst = 1'b1; flush = 1'b0;
    exm_w_en = 1'b0; exm_w_dest = 5'd0; exm_w_data = 32'd0;
    wb_w_en  = 1'b0; wb_w_dest  = 5'd0; wb_w_data  = 32'd0;
    // ori r4,r1,0x8001 held valid throughout reset
    fetch(1'b1, enc_i(6'h0D, 5'd1, 5'd4, 16'h8001), 32'h0000_0040);

    // ---- Reset: two cycles with if_valid=1 ----
    tick();
    tick();
    check("rst_valid",   id_valid,    0);
    check("rst_pc",      id_pc,       0);
    check("rst_op_a",    id_op_a,     0);
    check("rst_op_b",    id_op_b,     0);
    check("rst_imm",     id_imm,      0);
    check("rst_dest",    id_dest,     0);
    check("rst_w_en",    id_w_en,     0);
    check("rst_load",    id_is_load,  0);
    check("rst_store",   id_is_store, 0);
    check("rst_opcode",  id_opcode,   0);
    check("rst_funct",   id_funct,    0);
    check("rst_stall",   stall,       0);
    check("rst_raddr1",  reg_r_addr_1, 5'd1);
    check("rst_raddr2",  reg_r_addr_2, 5'd4);
    rst = 1'b0;

    // ---- Forwarding priority: add r6,r5,r0 ----
    fetch(1'b1, enc_r(5'd5, 5'd0, 5'd6, 6'h20), 32'h0000_0100);
    exm_w_en = 1'b1; exm_w_dest = 5'd5; exm_w_data = 32'hAAAA_0000;
    wb_w_en  = 1'b1; wb_w_dest  = 5'd5; wb_w_data  = 32'h0000_BBBB;
    tick();
    check("fwd_exm_op_a", id_op_a,  32'hAAAA_0000);
    check("fwd_op_b_r0",  id_op_b,  32'h0);
    check("fwd_valid",    id_valid, 1);
    check("fwd_pc",       id_pc,    32'h0000_0100);
    check("fwd_dest",     id_dest,  5'd6);
    check("fwd_w_en",     id_w_en,  1);
    check("fwd_funct",    id_funct, 6'h20);
    exm_w_en = 1'b0;
    tick();
    check("fwd_wb_op_a",  id_op_a,  32'h0000_BBBB);
    wb_w_en = 1'b0;
    tick();
    check("fwd_rf_op_a",  id_op_a,  32'h0000_0001);

    // ---- Register 0: addi r0,r0,7 with a pending write to r0 ----
    fetch(1'b1, enc_i(6'h08, 5'd0, 5'd0, 16'h0007), 32'h0000_0104);
    exm_w_en = 1'b1; exm_w_dest = 5'd0; exm_w_data = 32'hFFFF_FFFF;
    tick();
    check("r0_op_a",  id_op_a, 32'h0);
    check("r0_w_en",  id_w_en, 0);
    check("r0_imm",   id_imm,  32'h0000_0007);
    exm_w_en = 1'b0;

    // ---- Immediate / decode: ori r4,r1,0x8001 then sw r4,0(r1) ----
    fetch(1'b1, enc_i(6'h0D, 5'd1, 5'd4, 16'h8001), 32'h0000_0108);
    tick();
    check("ori_imm",    id_imm,    32'hFFFF_8001);
    check("ori_dest",   id_dest,   5'd4);
    check("ori_w_en",   id_w_en,   1);
    check("ori_op_a",   id_op_a,   32'h0000_0010);
    check("ori_opcode", id_opcode, 6'h0D);
    fetch(1'b1, enc_i(6'h2B, 5'd1, 5'd4, 16'h0000), 32'h0000_010C);
    tick();
    check("sw_store",   id_is_store, 1);
    check("sw_w_en",    id_w_en,     0);
    check("sw_load",    id_is_load,  0);
    check("sw_op_b",    id_op_b,     32'h0000_0044);

    // ---- Load-use: lw r8,4(r2) then add r9,r8,r3 ----
    fetch(1'b1, enc_i(6'h23, 5'd2, 5'd8, 16'h0004), 32'h0000_0110);
    tick();
    check("lw_load",  id_is_load, 1);
    check("lw_dest",  id_dest,    5'd8);
    check("lw_w_en",  id_w_en,    1);
    check("lw_imm",   id_imm,     32'h0000_0004);
    fetch(1'b1, enc_r(5'd8, 5'd3, 5'd9, 6'h20), 32'h0000_0114);
    settle();
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", id_valid,   0);
    check("lu_bubble_w_en",  id_w_en,    0);
    check("lu_bubble_load",  id_is_load, 0);
    // The load has moved to EX/MEM and its result is forwarded from there.
    exm_w_en = 1'b1; exm_w_dest = 5'd8; exm_w_data = 32'h1234_5678;
    settle();
    check("lu_stall_clear", stall, 0);
    tick();
    check("lu_add_valid", id_valid, 1);
    check("lu_add_dest",  id_dest,  5'd9);
    check("lu_add_op_a",  id_op_a,  32'h1234_5678);
    check("lu_add_op_b",  id_op_b,  32'h0000_0033);
    check("lu_add_pc",    id_pc,    32'h0000_0114);
    exm_w_en = 1'b0;

    // ---- Flush vs stall in the same cycle ----
    fetch(1'b1, enc_i(6'h23, 5'd2, 5'd8, 16'h0008), 32'h0000_0200);
    tick();
    fetch(1'b1, enc_r(5'd8, 5'd3, 5'd9, 6'h20), 32'h0000_0204);
    flush = 1'b1;
    settle();
    check("fl_stall", stall, 1);
    tick();
    check("fl_valid", id_valid, 0);
    check("fl_w_en",  id_w_en,  0);
    flush = 1'b0;
    settle();
    check("fl_stall_clear", stall, 0);
    tick();
    check("fl_next_valid", id_valid, 1);
    check("fl_next_op_a",  id_op_a,  32'h0000_0088);

    // ---- if_valid=0: control bits cleared ----
    fetch(1'b0, enc_i(6'h08, 5'd1, 5'd7, 16'h0001), 32'h0000_0300);
    tick();
    check("inv_valid", id_valid, 0);
    check("inv_w_en",  id_w_en,  0);

    // ---- Reset during a load-use stall ----
    fetch(1'b1, enc_i(6'h23, 5'd2, 5'd8, 16'h0000), 32'h0000_0400);
    tick();
    fetch(1'b1, enc_r(5'd3, 5'd8, 5'd10, 6'h22), 32'h0000_0404);
    settle();
    check("rs_stall_rt", stall, 1);
    rst = 1'b1;
    tick();
    check("rs_valid", id_valid, 0);
    check("rs_dest",  id_dest,  0);
    check("rs_stall", stall,    0);
    rst = 1'b0;
    tick();
    check("rs_after_valid", id_valid, 1);
    check("rs_after_dest",  id_dest,  5'd10);
    check("rs_after_funct", id_funct, 6'h22);
    check("rs_after_op_b",  id_op_b,  32'h0000_0088);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
